// File: rtl/prbs_gen_chk_if.sv
// Link-test bus for the PRBS generator/checker: stimulus/control from the test
// wrapper (master) and generator/checker status back from the block (slave).
interface prbs_gen_chk_if #(
  parameter int ERR_CNT_W = 16
);
  logic [1:0]           mode;
  logic                 en;
  logic                 inj_err;
  logic                 gen_out;
  logic                 rx_in;
  logic                 rx_valid;
  logic                 clr_cnt;
  logic                 locked;
  logic                 err_flag;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output mode, en, inj_err, rx_in, rx_valid, clr_cnt,
    input  gen_out, locked, err_flag, err_cnt
  );

  modport slave (
    input  mode, en, inj_err, rx_in, rx_valid, clr_cnt,
    output gen_out, locked, err_flag, err_cnt
  );
endinterface

// File: rtl/prbs_gen_chk.sv
// Serial PRBS7/15/23/31 generator with error injection, plus a self-synchronising
// checker (SEARCH/LOCKED) with windowed loss-of-lock and a saturating error count.
module prbs_gen_chk #(
  parameter int ERR_CNT_W  = 16,
  parameter int LOCK_CNT   = 32,
  parameter int WINDOW     = 64,
  parameter int UNLOCK_ERR = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  prbs_gen_chk_if.slave  bus
);
  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int WIN_W  = $clog2(WINDOW + 1);
  localparam int WERR_W = $clog2(UNLOCK_ERR + 1);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic [1:0]            mode_reg;
  logic [30:0]           gen_reg;
  logic                  inj_q_reg;
  logic [30:0]           chk_reg, chk_next;
  logic [4:0]            fill_reg, fill_next;
  logic [RUN_W-1:0]      run_reg, run_next;
  logic [WIN_W-1:0]      win_reg, win_next;
  logic [WERR_W-1:0]     werr_reg, werr_next;
  logic                  err_flag_reg, err_flag_next;
  logic [ERR_CNT_W-1:0]  err_cnt_reg, err_cnt_next;

  // Tap indices are N-1 and T-1 for the selected polynomial.
  logic [4:0]  n_idx, t_idx;
  logic [30:0] mask;
  always_comb begin
    n_idx = 5'd6;
    t_idx = 5'd5;
    case (bus.mode)
      2'b00: begin n_idx = 5'd6;  t_idx = 5'd5;  end
      2'b01: begin n_idx = 5'd14; t_idx = 5'd13; end
      2'b10: begin n_idx = 5'd22; t_idx = 5'd17; end
      default: begin n_idx = 5'd30; t_idx = 5'd27; end
    endcase
    mask = 31'h7FFF_FFFF >> (5'd30 - n_idx);
  end

  logic        mode_chg;
  logic        gen_fb;
  logic [30:0] gen_shift;
  logic        gen_zero;
  assign mode_chg  = (bus.mode != mode_reg);
  assign gen_fb    = gen_reg[n_idx] ^ gen_reg[t_idx];
  assign gen_shift = {gen_reg[29:0], gen_fb} & mask;
  assign gen_zero  = ((gen_reg & mask) == 31'd0);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mode_reg  <= 2'b00;
      gen_reg   <= 31'd1;
      inj_q_reg <= 1'b0;
    end else begin
      mode_reg <= bus.mode;
      if (mode_chg || gen_zero)
        gen_reg <= 31'd1;
      else if (bus.en)
        gen_reg <= gen_shift;
      if (bus.en)
        inj_q_reg <= bus.inj_err;
    end
  end

  assign bus.gen_out = gen_reg[n_idx] ^ inj_q_reg;

  // An all-zero history can never occur on a real PRBS, so it is an error too.
  logic pred, full, zero_hist, bit_err;
  assign pred      = chk_reg[n_idx] ^ chk_reg[t_idx];
  assign full      = (fill_reg == n_idx + 5'd1);
  assign zero_hist = ((chk_reg & mask) == 31'd0);
  assign bit_err   = full & ((bus.rx_in ^ pred) | zero_hist);

  always_comb begin
    state_next    = state_reg;
    chk_next      = chk_reg;
    fill_next     = fill_reg;
    run_next      = run_reg;
    win_next      = win_reg;
    werr_next     = werr_reg;
    err_flag_next = 1'b0;
    err_cnt_next  = err_cnt_reg;
    if (mode_chg) begin
      state_next = SEARCH;
      chk_next   = 31'd0;
      fill_next  = 5'd0;
      run_next   = '0;
      win_next   = '0;
      werr_next  = '0;
    end else if (bus.rx_valid) begin
      chk_next = {chk_reg[29:0], bus.rx_in} & mask;
      if (!full)
        fill_next = fill_reg + 5'd1;
      case (state_reg)
        SEARCH: begin
          if (full) begin
            if (bit_err) begin
              run_next = '0;
            end else if (run_reg == RUN_W'(LOCK_CNT - 1)) begin
              state_next = LOCKED;
              run_next   = '0;
              win_next   = '0;
              werr_next  = '0;
            end else begin
              run_next = run_reg + RUN_W'(1);
            end
          end
        end
        default: begin
          err_flag_next = bit_err;
          if (bit_err && (err_cnt_reg != '1))
            err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
          if (bit_err && (werr_reg == WERR_W'(UNLOCK_ERR - 1))) begin
            state_next = SEARCH;
            run_next   = '0;
            win_next   = '0;
            werr_next  = '0;
          end else if (win_reg == WIN_W'(WINDOW - 1)) begin
            win_next  = '0;
            werr_next = '0;
          end else begin
            win_next  = win_reg + WIN_W'(1);
            werr_next = werr_reg + WERR_W'(bit_err);
          end
        end
      endcase
    end
    if (bus.clr_cnt)
      err_cnt_next = '0;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg    <= SEARCH;
      chk_reg      <= 31'd0;
      fill_reg     <= 5'd0;
      run_reg      <= '0;
      win_reg      <= '0;
      werr_reg     <= '0;
      err_flag_reg <= 1'b0;
      err_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      chk_reg      <= chk_next;
      fill_reg     <= fill_next;
      run_reg      <= run_next;
      win_reg      <= win_next;
      werr_reg     <= werr_next;
      err_flag_reg <= err_flag_next;
      err_cnt_reg  <= err_cnt_next;
    end
  end

  assign bus.locked   = (state_reg == LOCKED);
  assign bus.err_flag = err_flag_reg;
  assign bus.err_cnt  = err_cnt_reg;
endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed bench for prbs_gen_chk: generator sequence, loopback lock in all modes,
// error injection, loss of lock, counter saturation/clear, mode change and reset.
module tb_prbs_gen_chk;
  logic clk = 1'b0;
  logic rst_n;
  logic lb;
  logic rx_inv;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  prbs_gen_chk_if #(.ERR_CNT_W(4)) bus();

  assign bus.rx_in    = lb ? (bus.gen_out ^ rx_inv) : 1'b0;
  assign bus.rx_valid = bus.en;

  prbs_gen_chk #(
    .ERR_CNT_W (4),
    .LOCK_CNT  (32),
    .WINDOW    (64),
    .UNLOCK_ERR(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] m);
    @(negedge clk);
    rst_n       = 1'b1;
    bus.mode    = m;
    bus.en      = 1'b0;
    bus.inj_err = 1'b0;
    bus.clr_cnt = 1'b0;
    lb          = 1'b1;
    rx_inv      = 1'b0;
    step(2);
    rst_n = 1'b0;
    step(2);
  endtask

  task automatic inj_pulse();
    bus.inj_err = 1'b1;
    step(1);
    bus.inj_err = 1'b0;
  endtask

  task automatic run_mode(input logic [1:0] m, input int first_exp, input int lock_exp);
    int first1;
    int first2;
    int lock_at;
    int ones;
    first1  = -1;
    first2  = -1;
    lock_at = -1;
    ones    = 0;
    do_reset(m);
    bus.en = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if (bus.gen_out && first1 < 0) first1 = k;
      if (k < 127) ones += int'(bus.gen_out);
      else if (bus.gen_out && first2 < 0) first2 = k;
      if (bus.locked && lock_at < 0) lock_at = k;
      step(1);
    end
    check($sformatf("m%0d_first_one", m), first1, first_exp);
    check($sformatf("m%0d_lock_at", m), lock_at, lock_exp);
    check($sformatf("m%0d_err_cnt_clean", m), int'(bus.err_cnt), 0);
    check($sformatf("m%0d_locked_end", m), int'(bus.locked), 1);
    if (m == 2'b00) begin
      check("m0_ones_in_127", ones, 64);
      check("m0_period_first_one", first2, 133);
    end
  endtask

  initial begin
    int pulses;
    int any_lock;
    int lock_at;
    rst_n       = 1'b0;
    bus.mode    = 2'b00;
    bus.en      = 1'b0;
    bus.inj_err = 1'b0;
    bus.clr_cnt = 1'b0;
    lb          = 1'b1;
    rx_inv      = 1'b0;
    #3 rst_n = 1'b1;
    step(1);
    check("rst_gen_out", int'(bus.gen_out), 0);
    check("rst_locked", int'(bus.locked), 0);
    check("rst_err_flag", int'(bus.err_flag), 0);
    check("rst_err_cnt", int'(bus.err_cnt), 0);

    run_mode(2'b11, 30, 63);
    run_mode(2'b10, 22, 55);
    run_mode(2'b01, 14, 47);
    run_mode(2'b00, 6, 39);

    // single injected bit -> three checker errors, lock held
    inj_pulse();
    step(1);
    check("inj_latency_flag", int'(bus.err_flag), 1);
    pulses = 1;
    for (int k = 0; k < 20; k++) begin
      step(1);
      pulses += int'(bus.err_flag);
    end
    check("inj_flag_pulses", pulses, 3);
    check("inj_err_cnt", int'(bus.err_cnt), 3);
    check("inj_locked", int'(bus.locked), 1);

    // spaced bursts push the 4-bit counter to saturation without losing lock
    step(20);
    for (int p = 0; p < 6; p++) begin
      inj_pulse();
      step(39);
    end
    check("sat_err_cnt", int'(bus.err_cnt), 15);
    check("sat_locked", int'(bus.locked), 1);
    inj_pulse();
    bus.clr_cnt = 1'b1;
    step(1);
    bus.clr_cnt = 1'b0;
    check("clr_wins_cnt", int'(bus.err_cnt), 0);
    check("clr_wins_flag", int'(bus.err_flag), 1);
    step(10);
    check("post_clr_cnt", int'(bus.err_cnt), 2);

    // constant-zero line never locks
    do_reset(2'b00);
    lb     = 1'b0;
    bus.en = 1'b1;
    any_lock = 0;
    for (int k = 0; k < 300; k++) begin
      step(1);
      any_lock |= int'(bus.locked);
    end
    check("zero_line_no_lock", any_lock, 0);
    check("zero_line_err_cnt", int'(bus.err_cnt), 0);

    // inverted line after lock -> loss of lock with 8 counted errors
    do_reset(2'b00);
    bus.en = 1'b1;
    step(39);
    check("inv_pre_locked", int'(bus.locked), 1);
    rx_inv = 1'b1;
    step(12);
    check("inv_unlocked", int'(bus.locked), 0);
    check("inv_err_cnt", int'(bus.err_cnt), 8);
    rx_inv = 1'b0;

    // mode change while locked, then async reset mid-stream
    do_reset(2'b00);
    bus.en = 1'b1;
    step(60);
    inj_pulse();
    step(20);
    check("mc_pre_err_cnt", int'(bus.err_cnt), 3);
    bus.mode = 2'b11;
    step(1);
    check("mc_unlocked", int'(bus.locked), 0);
    check("mc_err_cnt_kept", int'(bus.err_cnt), 3);
    lock_at = -1;
    for (int k = 1; k <= 100; k++) begin
      step(1);
      if (bus.locked && lock_at < 0) lock_at = k;
    end
    check("mc_relock_at", lock_at, 63);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("arst_gen_out", int'(bus.gen_out), 0);
    check("arst_locked", int'(bus.locked), 0);
    check("arst_err_flag", int'(bus.err_flag), 0);
    check("arst_err_cnt", int'(bus.err_cnt), 0);
    #2 rst_n = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
